// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: opcodes, funct codes, ALU codes, state encodings and control word
// for the multicycle MIPS controller; ILLEGAL_OP_TRAP_EN selects TRAP vs NOP for unknown opcodes.
package multicycle_control_fsm_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011100;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_MUL = 3'b011;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    // Case defaults catch X/Z opcodes, so the state register never sees X.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEMADR;
            OP_RTYPE:     return S_EXEC;
            OP_ADDI:      return S_ADDIEX;
            OP_BEQ:       return S_BRANCH;
            OP_J:         return S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
            default:      return S_TRAP;
`else
            default:      return S_FETCH;
`endif
        endcase
    endfunction

    function automatic state_t mem_next(input logic [5:0] op);
        case (op)
            OP_LW:   return S_MEMRD;
            default: return S_MEMWR;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// alu_decoder: maps {alu_op, funct} to alu_ctrl; funct_illegal exists only with ILLEGAL_OP_TRAP_EN.
module alu_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic       funct_illegal
`endif
);

    logic [2:0] fn_ctrl;

    always_comb begin
        case (funct)
            FN_SUB:  fn_ctrl = ALU_SUB;
            FN_SLT:  fn_ctrl = ALU_SLT;
            FN_MUL:  fn_ctrl = ALU_MUL;
            default: fn_ctrl = ALU_ADD;
        endcase
        alu_ctrl = alu_op == AOP_SUB ? ALU_SUB : alu_op == AOP_FUNCT ? fn_ctrl : ALU_ADD;
    end

`ifdef ILLEGAL_OP_TRAP_EN
    assign funct_illegal = alu_op == AOP_FUNCT && !(funct inside {FN_ADD, FN_SUB, FN_SLT, FN_MUL});
`endif

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore controller for a shared-ALU multicycle MIPS datapath.
// ILLEGAL_OP_TRAP_EN: unknown opcode/funct enters a sticky TRAP state instead of acting as NOP/ADD.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_ctrl,
    output logic [1:0]         pc_src,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_t     state_q, state_d;
    ctrl_t      raw, ctrl;
    logic [2:0] dec_ctrl;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       funct_illegal;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Unlisted encodings (and TRAP when the trap is compiled out) recover to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = decode_next(opcode);
            S_MEMADR: state_d = mem_next(opcode);
            S_MEMRD:  state_d = S_MEMWB;
`ifdef ILLEGAL_OP_TRAP_EN
            S_EXEC:   state_d = funct_illegal ? S_TRAP : S_ALUWB;
            S_TRAP:   state_d = S_TRAP;
`else
            S_EXEC:   state_d = S_ALUWB;
`endif
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        raw = '0;
        case (state_q)
            S_FETCH: begin
                raw.ir_write  = 1'b1;
                raw.alu_src_b = SRCB_4;
                raw.pc_src    = PC_ALU;
                raw.pc_write  = 1'b1;
            end
            S_DECODE: raw.alu_src_b = SRCB_BR;
            S_MEMADR, S_ADDIEX: begin
                raw.alu_src_a = 1'b1;
                raw.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: raw.iord = 1'b1;
            S_MEMWB: begin
                raw.mem_to_reg = 1'b1;
                raw.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                raw.iord      = 1'b1;
                raw.mem_write = 1'b1;
            end
            S_EXEC: begin
                raw.alu_src_a = 1'b1;
                raw.alu_src_b = SRCB_REG;
                raw.alu_op    = AOP_FUNCT;
            end
            S_ALUWB: begin
                raw.reg_dst   = 1'b1;
                raw.reg_write = 1'b1;
                raw.alu_op    = AOP_FUNCT;
            end
            S_ADDIWB: raw.reg_write = 1'b1;
            S_BRANCH: begin
                raw.alu_src_a = 1'b1;
                raw.alu_src_b = SRCB_REG;
                raw.alu_op    = AOP_SUB;
                raw.pc_src    = PC_ALUOUT;
                raw.branch    = 1'b1;
            end
            S_JUMP: begin
                raw.pc_src   = PC_JUMP;
                raw.pc_write = 1'b1;
            end
            default: raw = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op        (raw.alu_op),
        .funct         (funct),
        .alu_ctrl      (dec_ctrl)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .funct_illegal (funct_illegal)
`endif
    );

    // Reset forces every output low even though FETCH would otherwise assert strobes.
    assign ctrl       = rst ? '0 : raw;
    assign alu_ctrl   = rst ? 3'b000 : dec_ctrl;
    assign pc_en      = ctrl.pc_write | (ctrl.branch & zero);
    assign iord       = ctrl.iord;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_dst    = ctrl.reg_dst;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign state_dbg  = STATE_W'(state_q);

`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op = !rst && state_q == S_TRAP;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: table-driven per-cycle checks of state and outputs plus reset/trap sequences.
module tb_multicycle_control_fsm;
    import multicycle_control_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state_dbg;
    logic [15:0] outs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    // {pc_en,iord,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a,alu_src_b,alu_ctrl,pc_src,illegal_op}
    assign outs = {pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                   alu_src_b, alu_ctrl, pc_src, illegal_op};

    localparam logic [15:0] E_FETCH  = 16'b1_0_0_1_0_0_0_0_01_010_00_0;
    localparam logic [15:0] E_DECODE = 16'b0_0_0_0_0_0_0_0_11_010_00_0;
    localparam logic [15:0] E_MEMADR = 16'b0_0_0_0_0_0_0_1_10_010_00_0;
    localparam logic [15:0] E_MEMRD  = 16'b0_1_0_0_0_0_0_0_00_010_00_0;
    localparam logic [15:0] E_MEMWB  = 16'b0_0_0_0_1_0_1_0_00_010_00_0;
    localparam logic [15:0] E_MEMWR  = 16'b0_1_1_0_0_0_0_0_00_010_00_0;
    localparam logic [15:0] E_EX_ADD = 16'b0_0_0_0_0_0_0_1_00_010_00_0;
    localparam logic [15:0] E_EX_SUB = 16'b0_0_0_0_0_0_0_1_00_110_00_0;
    localparam logic [15:0] E_EX_SLT = 16'b0_0_0_0_0_0_0_1_00_111_00_0;
    localparam logic [15:0] E_EX_MUL = 16'b0_0_0_0_0_0_0_1_00_011_00_0;
    localparam logic [15:0] E_WB_ADD = 16'b0_0_0_0_0_1_1_0_00_010_00_0;
    localparam logic [15:0] E_WB_SUB = 16'b0_0_0_0_0_1_1_0_00_110_00_0;
    localparam logic [15:0] E_WB_SLT = 16'b0_0_0_0_0_1_1_0_00_111_00_0;
    localparam logic [15:0] E_WB_MUL = 16'b0_0_0_0_0_1_1_0_00_011_00_0;
    localparam logic [15:0] E_ADDIWB = 16'b0_0_0_0_0_0_1_0_00_010_00_0;
    localparam logic [15:0] E_BR_T   = 16'b1_0_0_0_0_0_0_1_00_110_01_0;
    localparam logic [15:0] E_BR_N   = 16'b0_0_0_0_0_0_0_1_00_110_01_0;
    localparam logic [15:0] E_JUMP   = 16'b1_0_0_0_0_0_0_0_00_010_10_0;
    localparam logic [15:0] E_TRAP   = 16'b0_0_0_0_0_0_0_0_00_010_00_1;
    localparam logic [15:0] E_RESET  = 16'b0;

    typedef struct {
        string      nm;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic [3:0] st;
        logic [15:0] ex;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [3:0] st, input logic [15:0] ex);
        vec_t v;
        v.nm = nm; v.op = op; v.fn = fn; v.z = z; v.st = st; v.ex = ex;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [3:0] st, input logic [15:0] ex);
        checks++;
        if (state_dbg !== st || outs !== ex) begin
            errors++;
            $display("FAIL %s: got state=%0d out=%b, want state=%0d out=%b", nm, state_dbg, outs, st, ex);
        end
    endtask

    task automatic step_chk(input string nm, input logic [3:0] st, input logic [15:0] ex);
        @(negedge clk);
        #1 chk(nm, st, ex);
    endtask

    initial begin
        add("lw_fetch",   6'b100011, 6'b0, 1'b0, S_FETCH,  E_FETCH);
        add("lw_decode",  6'b100011, 6'b0, 1'b0, S_DECODE, E_DECODE);
        add("lw_memadr",  6'b100011, 6'b0, 1'b0, S_MEMADR, E_MEMADR);
        add("lw_memrd",   6'b100011, 6'b0, 1'b0, S_MEMRD,  E_MEMRD);
        add("lw_memwb",   6'b100011, 6'b0, 1'b0, S_MEMWB,  E_MEMWB);
        add("sw_fetch",   6'b101011, 6'b0, 1'b1, S_FETCH,  E_FETCH);
        add("sw_decode",  6'b101011, 6'b0, 1'b1, S_DECODE, E_DECODE);
        add("sw_memadr",  6'b101011, 6'b0, 1'b1, S_MEMADR, E_MEMADR);
        add("sw_memwr",   6'b101011, 6'b0, 1'b1, S_MEMWR,  E_MEMWR);
        add("sub_fetch",  6'b000000, 6'b100010, 1'b0, S_FETCH,  E_FETCH);
        add("sub_decode", 6'b000000, 6'b100010, 1'b0, S_DECODE, E_DECODE);
        add("sub_exec",   6'b000000, 6'b100010, 1'b0, S_EXEC,   E_EX_SUB);
        add("sub_aluwb",  6'b000000, 6'b100010, 1'b0, S_ALUWB,  E_WB_SUB);
        add("slt_fetch",  6'b000000, 6'b101010, 1'b0, S_FETCH,  E_FETCH);
        add("slt_decode", 6'b000000, 6'b101010, 1'b0, S_DECODE, E_DECODE);
        add("slt_exec",   6'b000000, 6'b101010, 1'b0, S_EXEC,   E_EX_SLT);
        add("slt_aluwb",  6'b000000, 6'b101010, 1'b0, S_ALUWB,  E_WB_SLT);
        add("mul_fetch",  6'b000000, 6'b011100, 1'b0, S_FETCH,  E_FETCH);
        add("mul_decode", 6'b000000, 6'b011100, 1'b0, S_DECODE, E_DECODE);
        add("mul_exec",   6'b000000, 6'b011100, 1'b0, S_EXEC,   E_EX_MUL);
        add("mul_aluwb",  6'b000000, 6'b011100, 1'b0, S_ALUWB,  E_WB_MUL);
        add("add_fetch",  6'b000000, 6'b100000, 1'b0, S_FETCH,  E_FETCH);
        add("add_decode", 6'b000000, 6'b100000, 1'b0, S_DECODE, E_DECODE);
        add("add_exec",   6'b000000, 6'b100000, 1'b0, S_EXEC,   E_EX_ADD);
        add("add_aluwb",  6'b000000, 6'b100000, 1'b0, S_ALUWB,  E_WB_ADD);
        add("addi_fetch", 6'b001000, 6'b0, 1'b0, S_FETCH,  E_FETCH);
        add("addi_decode",6'b001000, 6'b0, 1'b0, S_DECODE, E_DECODE);
        add("addi_ex",    6'b001000, 6'b0, 1'b0, S_ADDIEX, E_MEMADR);
        add("addi_wb",    6'b001000, 6'b0, 1'b0, S_ADDIWB, E_ADDIWB);
        add("beqt_fetch", 6'b000100, 6'b0, 1'b1, S_FETCH,  E_FETCH);
        add("beqt_decode",6'b000100, 6'b0, 1'b1, S_DECODE, E_DECODE);
        add("beqt_branch",6'b000100, 6'b0, 1'b1, S_BRANCH, E_BR_T);
        add("beqn_fetch", 6'b000100, 6'b0, 1'b0, S_FETCH,  E_FETCH);
        add("beqn_decode",6'b000100, 6'b0, 1'b0, S_DECODE, E_DECODE);
        add("beqn_branch",6'b000100, 6'b0, 1'b0, S_BRANCH, E_BR_N);
`ifndef ILLEGAL_OP_TRAP_EN
        add("badfn_fetch",6'b000000, 6'b111111, 1'b0, S_FETCH,  E_FETCH);
        add("badfn_dec",  6'b000000, 6'b111111, 1'b0, S_DECODE, E_DECODE);
        add("badfn_exec", 6'b000000, 6'b111111, 1'b0, S_EXEC,   E_EX_ADD);
        add("badfn_aluwb",6'b000000, 6'b111111, 1'b0, S_ALUWB,  E_WB_ADD);
        add("badop_fetch",6'b111111, 6'b0, 1'b0, S_FETCH,  E_FETCH);
        add("badop_dec",  6'b111111, 6'b0, 1'b0, S_DECODE, E_DECODE);
`endif
        add("j_fetch",    6'b000010, 6'b0, 1'b0, S_FETCH,  E_FETCH);
        add("j_decode",   6'b000010, 6'b0, 1'b0, S_DECODE, E_DECODE);
        add("j_jump",     6'b000010, 6'b0, 1'b0, S_JUMP,   E_JUMP);

        rst = 1'b1;
        opcode = 6'b0;
        funct = 6'b0;
        zero = 1'b0;
        step_chk("reset_hold", S_FETCH, E_RESET);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            opcode = vq[i].op;
            funct = vq[i].fn;
            zero = vq[i].z;
            #1 chk(vq[i].nm, vq[i].st, vq[i].ex);
            @(negedge clk);
        end

        // Abort a load in MEMRD with an asynchronous reset.
        opcode = 6'b100011;
        funct = 6'b0;
        zero = 1'b0;
        #1 chk("seq_lw_fetch", S_FETCH, E_FETCH);
        step_chk("seq_lw_decode", S_DECODE, E_DECODE);
        step_chk("seq_lw_memadr", S_MEMADR, E_MEMADR);
        step_chk("seq_lw_memrd", S_MEMRD, E_MEMRD);
        rst = 1'b1;
        #1 chk("rst_async", S_FETCH, E_RESET);
        step_chk("rst_held", S_FETCH, E_RESET);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_fetch", S_FETCH, E_FETCH);
        step_chk("post_rst_decode", S_DECODE, E_DECODE);

`ifdef ILLEGAL_OP_TRAP_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        opcode = 6'b111111;
        #1 chk("trap_op_fetch", S_FETCH, E_FETCH);
        step_chk("trap_op_decode", S_DECODE, E_DECODE);
        for (int k = 0; k < 4; k++) step_chk("trap_op_hold", S_TRAP, E_TRAP);
        rst = 1'b1;
        #1 chk("trap_op_clear", S_FETCH, E_RESET);
        @(negedge clk);
        rst = 1'b0;
        opcode = 6'b000000;
        funct = 6'b111111;
        #1 chk("trap_fn_fetch", S_FETCH, E_FETCH);
        step_chk("trap_fn_decode", S_DECODE, E_DECODE);
        step_chk("trap_fn_exec", S_EXEC, E_EX_ADD);
        for (int k = 0; k < 3; k++) step_chk("trap_fn_hold", S_TRAP, E_TRAP);
        rst = 1'b1;
        #1 chk("trap_fn_clear", S_FETCH, E_RESET);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
